// File: rtl/xlit_gen_pkg.sv
// Shared types and constants for the xlit frame-traffic generator.
// Holds the FSM state encoding, payload modes and the LFSR step function.
package xlit_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FRAME,
        ST_GAP,
        ST_FIN
    } gen_state_e;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_INCR  = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Fibonacci x^8+x^6+x^5+x^4+1: shift left, feed the tap parity into bit 0.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/xlit_frame_gen_if.sv
// Generator-to-xmit beat bus: payload, frame/control qualifiers and the ready backpressure.
interface xlit_frame_gen_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 12
) ();
    logic [DATA_W-1:0]  gen_data;
    logic               gen_data_valid;
    logic               gen_frame_valid;
    logic [2*LEN_W-1:0] gen_ctrl;
    logic               gen_hi_priority;
    logic               gen_ready;

    modport master (
        output gen_data, gen_data_valid, gen_frame_valid, gen_ctrl, gen_hi_priority,
        input  gen_ready
    );

    modport slave (
        input  gen_data, gen_data_valid, gen_frame_valid, gen_ctrl, gen_hi_priority,
        output gen_ready
    );
endinterface

// File: rtl/xlit_lfsr8.sv
// 8-bit payload LFSR: load has priority over step, value is the current register.
module xlit_lfsr8
    import xlit_gen_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [7:0] value
);
    logic [7:0] lfsr_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n)
            lfsr_q <= 8'h00;
        else if (load)
            lfsr_q <= seed;
        else if (step)
            lfsr_q <= lfsr8_next(lfsr_q);
    end

    assign value = lfsr_q;
endmodule

// File: rtl/xlit_frame_gen.sv
// Interleaved hi/lo priority frame generator feeding the xmit front end,
// with programmable ratio, lengths, inter-frame gap and payload pattern.
module xlit_frame_gen
    import xlit_gen_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 12,
    parameter int CNT_W  = 8,
    parameter int GAP_W  = 8
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [CNT_W-1:0]  cfg_num_hi,
    input  logic [CNT_W-1:0]  cfg_num_lo,
    input  logic [CNT_W-1:0]  cfg_num_loops,
    input  logic [LEN_W-1:0]  cfg_len_hi,
    input  logic [LEN_W-1:0]  cfg_len_lo,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic [1:0]        cfg_mode,
    input  logic [DATA_W-1:0] cfg_seed_hi,
    input  logic [DATA_W-1:0] cfg_seed_lo,
    xlit_frame_gen_if.master  gen,
    output logic              gen_busy,
    output logic              gen_done,
    output logic [15:0]       gen_frames
);
    gen_state_e state_q, state_d;

    logic [CNT_W-1:0]  num_hi_q, num_lo_q, loops_q, frame_cnt_q, loop_cnt_q, class_num, loop_nxt;
    logic [CNT_W:0]    frame_nxt;
    logic [LEN_W-1:0]  len_hi_q, len_lo_q, beat_idx_q, len_eff;
    logic [GAP_W-1:0]  gap_q, gap_cnt_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] seq_hi_q, seq_lo_q, cur_seq, next_seq, first_seq;
    logic              cur_hi_q, next_hi, class_done, round_done, run_done;
    logic              accept, beat_last, frame_end, no_frames;
    logic              lfsr_load, lfsr_step;
    logic [7:0]        lfsr_seed, lfsr_value;

    // Frame bookkeeping; next_seq is the sequence value the following frame will use,
    // which for the same class is this frame's value plus one.
    always_comb begin
        len_eff = cur_hi_q ? len_hi_q : len_lo_q;
        if (len_eff == '0)
            len_eff = LEN_W'(1);
        cur_seq    = cur_hi_q ? seq_hi_q : seq_lo_q;
        first_seq  = (num_hi_q != '0) ? seq_hi_q : seq_lo_q;
        no_frames  = (num_hi_q == '0) && (num_lo_q == '0);
        accept     = (state_q == ST_FRAME) && gen.gen_ready;
        beat_last  = (beat_idx_q == len_eff - LEN_W'(1));
        frame_end  = accept && beat_last;
        class_num  = cur_hi_q ? num_hi_q : num_lo_q;
        frame_nxt  = {1'b0, frame_cnt_q} + (CNT_W+1)'(1);
        class_done = (frame_nxt >= {1'b0, class_num});
        round_done = class_done && (!cur_hi_q || (num_lo_q == '0));
        loop_nxt   = loop_cnt_q + CNT_W'(1);
        run_done   = round_done && (loops_q != '0) && (loop_nxt == loops_q);
        if (!class_done)
            next_hi = cur_hi_q;
        else if (cur_hi_q && (num_lo_q != '0))
            next_hi = 1'b0;
        else
            next_hi = (num_hi_q != '0);
        if (next_hi == cur_hi_q)
            next_seq = cur_seq + DATA_W'(1);
        else
            next_seq = next_hi ? seq_hi_q : seq_lo_q;
        lfsr_load = (state_q == ST_LOAD) || frame_end;
        lfsr_seed = (state_q == ST_LOAD) ? (8'(first_seq) | 8'h01) : (8'(next_seq) | 8'h01);
        lfsr_step = accept && !beat_last;
    end

    xlit_lfsr8 u_lfsr (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .load    (lfsr_load),
        .step    (lfsr_step),
        .seed    (lfsr_seed),
        .value   (lfsr_value)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cfg_start) state_d = ST_LOAD;
            ST_LOAD:  state_d = no_frames ? ST_FIN : ST_FRAME;
            ST_FRAME: begin
                if (frame_end) begin
                    if (run_done)
                        state_d = ST_FIN;
                    else if (gap_q == '0)
                        state_d = ST_FRAME;
                    else
                        state_d = ST_GAP;
                end
            end
            ST_GAP:   if (gap_cnt_q == '0) state_d = ST_FRAME;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (cfg_abort)
            state_d = ST_IDLE;
    end

    // Abort freezes every counter so a truncated frame never reaches gen_frames.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            num_hi_q    <= '0;
            num_lo_q    <= '0;
            loops_q     <= '0;
            len_hi_q    <= '0;
            len_lo_q    <= '0;
            gap_q       <= '0;
            mode_q      <= '0;
            seq_hi_q    <= '0;
            seq_lo_q    <= '0;
            frame_cnt_q <= '0;
            loop_cnt_q  <= '0;
            beat_idx_q  <= '0;
            gap_cnt_q   <= '0;
            cur_hi_q    <= 1'b0;
            gen_frames  <= 16'd0;
        end else if (!cfg_abort) begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        num_hi_q    <= cfg_num_hi;
                        num_lo_q    <= cfg_num_lo;
                        loops_q     <= cfg_num_loops;
                        len_hi_q    <= cfg_len_hi;
                        len_lo_q    <= cfg_len_lo;
                        gap_q       <= cfg_gap;
                        mode_q      <= cfg_mode;
                        seq_hi_q    <= cfg_seed_hi;
                        seq_lo_q    <= cfg_seed_lo;
                        frame_cnt_q <= '0;
                        loop_cnt_q  <= '0;
                        beat_idx_q  <= '0;
                        gen_frames  <= 16'd0;
                    end
                end
                ST_LOAD: begin
                    cur_hi_q    <= (num_hi_q != '0);
                    frame_cnt_q <= '0;
                    beat_idx_q  <= '0;
                end
                ST_FRAME: begin
                    if (accept) begin
                        if (beat_last) begin
                            beat_idx_q <= '0;
                            if (gen_frames != 16'hFFFF)
                                gen_frames <= gen_frames + 16'd1;
                            if (cur_hi_q)
                                seq_hi_q <= seq_hi_q + DATA_W'(1);
                            else
                                seq_lo_q <= seq_lo_q + DATA_W'(1);
                            frame_cnt_q <= class_done ? '0 : frame_nxt[CNT_W-1:0];
                            if (round_done)
                                loop_cnt_q <= loop_nxt;
                            cur_hi_q  <= next_hi;
                            gap_cnt_q <= gap_q - GAP_W'(1);
                        end else begin
                            beat_idx_q <= beat_idx_q + LEN_W'(1);
                        end
                    end
                end
                ST_GAP:  gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        gen.gen_data        = '0;
        gen.gen_data_valid  = 1'b0;
        gen.gen_frame_valid = 1'b0;
        gen.gen_ctrl        = '0;
        gen.gen_hi_priority = 1'b0;
        gen_busy            = (state_q != ST_IDLE);
        gen_done            = (state_q == ST_FIN);
        if (state_q == ST_FRAME) begin
            gen.gen_data_valid  = 1'b1;
            gen.gen_hi_priority = cur_hi_q;
            gen.gen_frame_valid = (beat_idx_q == '0);
            if (beat_idx_q == '0)
                gen.gen_ctrl = {len_eff, len_eff};
            case (mode_q)
                MODE_CONST: gen.gen_data = cur_seq;
                MODE_INCR:  gen.gen_data = cur_seq + DATA_W'(beat_idx_q);
                MODE_LFSR:  gen.gen_data = DATA_W'(lfsr_value);
                default:    gen.gen_data = cur_seq;
            endcase
        end
    end
endmodule

// File: tb/tb_xlit_frame_gen.sv
// Self-checking bench for xlit_frame_gen: directed scenarios plus randomized configs,
// compared beat-by-beat against a frame-list reference model.
module tb_xlit_frame_gen;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 12;
    localparam int CNT_W  = 8;
    localparam int GAP_W  = 8;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              cfg_start = 1'b0, cfg_abort = 1'b0;
    logic [CNT_W-1:0]  cfg_num_hi = '0, cfg_num_lo = '0, cfg_num_loops = '0;
    logic [LEN_W-1:0]  cfg_len_hi = '0, cfg_len_lo = '0;
    logic [GAP_W-1:0]  cfg_gap = '0;
    logic [1:0]        cfg_mode = '0;
    logic [DATA_W-1:0] cfg_seed_hi = '0, cfg_seed_lo = '0;
    logic              gen_busy, gen_done;
    logic [15:0]       gen_frames;

    xlit_frame_gen_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) gen_bus ();

    xlit_frame_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .cfg_num_hi    (cfg_num_hi),
        .cfg_num_lo    (cfg_num_lo),
        .cfg_num_loops (cfg_num_loops),
        .cfg_len_hi    (cfg_len_hi),
        .cfg_len_lo    (cfg_len_lo),
        .cfg_gap       (cfg_gap),
        .cfg_mode      (cfg_mode),
        .cfg_seed_hi   (cfg_seed_hi),
        .cfg_seed_lo   (cfg_seed_lo),
        .gen           (gen_bus),
        .gen_busy      (gen_busy),
        .gen_done      (gen_done),
        .gen_frames    (gen_frames)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0]  data;
        logic        fv;
        logic [23:0] ctrl;
        logic        hi;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_model(input logic [7:0] s);
        int v, fb;
        v  = int'(s);
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return 8'(((v * 2) + fb) % 256);
    endfunction

    // Expands the whole run into the list of beats the generator must deliver, in order.
    task automatic build_model(input int nhi, input int nlo, input int loops, input int lhi,
                               input int llo, input int mode, input int shi, input int slo);
        int seq_h, seq_l, n, len, seq;
        logic [7:0] lf;
        beat_t b;
        seq_h = shi;
        seq_l = slo;
        exp_q.delete();
        for (int r = 0; r < loops; r++) begin
            for (int c = 0; c < 2; c++) begin
                n = (c == 0) ? nhi : nlo;
                for (int f = 0; f < n; f++) begin
                    len = (c == 0) ? lhi : llo;
                    if (len == 0) len = 1;
                    seq = (c == 0) ? seq_h : seq_l;
                    lf  = 8'(seq) | 8'h01;
                    for (int k = 0; k < len; k++) begin
                        case (mode)
                            1:       b.data = 8'((seq + k) % 256);
                            2:       b.data = lf;
                            default: b.data = 8'(seq);
                        endcase
                        b.fv   = (k == 0);
                        b.ctrl = (k == 0) ? {12'(len), 12'(len)} : 24'h0;
                        b.hi   = (c == 0);
                        b.last = (k == len - 1);
                        exp_q.push_back(b);
                        lf = lfsr_model(lf);
                    end
                    if (c == 0) seq_h = (seq_h + 1) % 256;
                    else        seq_l = (seq_l + 1) % 256;
                end
            end
        end
    endtask

    task automatic applyStimulus(input int nhi, input int nlo, input int loops, input int lhi,
                                 input int llo, input int gap, input int mode, input int shi, input int slo);
        cfg_num_hi    = CNT_W'(nhi);
        cfg_num_lo    = CNT_W'(nlo);
        cfg_num_loops = CNT_W'(loops);
        cfg_len_hi    = LEN_W'(lhi);
        cfg_len_lo    = LEN_W'(llo);
        cfg_gap       = GAP_W'(gap);
        cfg_mode      = 2'(mode);
        cfg_seed_hi   = DATA_W'(shi);
        cfg_seed_lo   = DATA_W'(slo);
        build_model(nhi, nlo, (loops == 0) ? 3 : loops, lhi, llo, mode, shi, slo);
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: return ($urandom_range(0, 9) < 7);
        endcase
    endfunction

    // Starts a run and follows it cycle by cycle; stop_beat >= 0 aborts (or resets)
    // when beat stop_beat of frame stop_frame is presented.
    task automatic run_frames(input int ready_mode, input int exp_frames, input bit finite,
                              input int stop_frame, input int stop_beat, input bit use_reset,
                              output int busy_cycles);
        int cyc, done_cnt, frames_acc, beat_in_frame, idle_run;
        bit in_gap, stalled, finished, first, r;
        logic [34:0] snap, cur;
        beat_t b;
        cyc = 0; done_cnt = 0; frames_acc = 0; beat_in_frame = 0; idle_run = 0;
        in_gap = 0; stalled = 0; finished = 0; first = 1; snap = '0;
        gen_bus.gen_ready = 1'b0;
        cfg_start = 1'b1;
        @(posedge clk_sys); #1;
        cfg_start = 1'b0;
        busy_cycles = gen_busy ? 1 : 0;
        checkOutput("load_valid", 64'(gen_bus.gen_data_valid), 64'd0);
        checkOutput("load_busy", 64'(gen_busy), 64'd1);
        @(posedge clk_sys); #1;
        while (!finished && cyc < 20000) begin
            cur = {gen_bus.gen_data_valid, gen_bus.gen_frame_valid, gen_bus.gen_hi_priority,
                   gen_bus.gen_ctrl, gen_bus.gen_data};
            if (gen_busy) busy_cycles++;
            if (first && exp_q.size() > 0)
                checkOutput("first_beat", 64'(gen_bus.gen_data_valid), 64'd1);
            first = 0;
            if (stalled) begin
                checkOutput("stall_hold", 64'(cur), 64'(snap));
                stalled = 0;
            end
            if (gen_done) begin
                done_cnt++;
                finished = 1;
                checkOutput("done_frames", 64'(gen_frames), 64'(exp_frames));
            end else if (gen_bus.gen_data_valid) begin
                if (stop_beat >= 0 && frames_acc == stop_frame && beat_in_frame == stop_beat) begin
                    if (use_reset) reset_n = 1'b0;
                    else           cfg_abort = 1'b1;
                    gen_bus.gen_ready = 1'b1;
                    @(posedge clk_sys); #1;
                    checkOutput("stop_outputs", 64'({gen_bus.gen_data_valid, gen_bus.gen_frame_valid,
                                gen_bus.gen_hi_priority, gen_bus.gen_ctrl, gen_bus.gen_data}), 64'd0);
                    checkOutput("stop_busy", 64'(gen_busy), 64'd0);
                    checkOutput("stop_done", 64'(gen_done), 64'd0);
                    checkOutput("stop_frames", 64'(gen_frames), 64'(exp_frames));
                    cfg_abort = 1'b0;
                    reset_n   = 1'b1;
                    finished  = 1;
                end else begin
                    if (in_gap) begin
                        checkOutput("gap_len", 64'(idle_run), 64'(cfg_gap));
                        in_gap = 0;
                    end
                    r = pick_ready(ready_mode, cyc);
                    gen_bus.gen_ready = r;
                    if (r) begin
                        if (exp_q.size() == 0) begin
                            checkOutput("extra_beat", 64'd1, 64'd0);
                        end else begin
                            b = exp_q.pop_front();
                            checkOutput("data", 64'(gen_bus.gen_data), 64'(b.data));
                            checkOutput("frame_valid", 64'(gen_bus.gen_frame_valid), 64'(b.fv));
                            checkOutput("ctrl", 64'(gen_bus.gen_ctrl), 64'(b.ctrl));
                            checkOutput("hi_priority", 64'(gen_bus.gen_hi_priority), 64'(b.hi));
                            beat_in_frame++;
                            if (b.last) begin
                                frames_acc++;
                                beat_in_frame = 0;
                                if (exp_q.size() > 0) begin
                                    in_gap   = 1;
                                    idle_run = 0;
                                end
                            end
                        end
                    end else begin
                        stalled = 1;
                        snap    = cur;
                    end
                end
            end else if (in_gap) begin
                idle_run++;
            end
            if (!finished) begin
                @(posedge clk_sys); #1;
                cyc++;
            end
        end
        gen_bus.gen_ready = 1'b0;
        if (finite) begin
            checkOutput("done_seen", 64'(done_cnt), 64'd1);
            checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
            @(posedge clk_sys); #1;
            checkOutput("end_busy", 64'(gen_busy), 64'd0);
            checkOutput("end_done", 64'(gen_done), 64'd0);
            checkOutput("end_frames", 64'(gen_frames), 64'(exp_frames));
        end else begin
            checkOutput("stop_reached", 64'(finished), 64'd1);
            checkOutput("stop_no_done", 64'(done_cnt), 64'd0);
            @(posedge clk_sys); #1;
            checkOutput("stop_after_done", 64'(gen_done), 64'd0);
            checkOutput("stop_after_valid", 64'(gen_bus.gen_data_valid), 64'd0);
        end
    endtask

    initial begin
        int busy;
        gen_bus.gen_ready = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        checkOutput("rst_busy", 64'(gen_busy), 64'd0);
        checkOutput("rst_done", 64'(gen_done), 64'd0);
        checkOutput("rst_frames", 64'(gen_frames), 64'd0);
        checkOutput("rst_bus", 64'({gen_bus.gen_data_valid, gen_bus.gen_frame_valid,
                    gen_bus.gen_hi_priority, gen_bus.gen_ctrl, gen_bus.gen_data}), 64'd0);
        reset_n = 1'b1;
        @(posedge clk_sys); #1;

        $display("[TB] long hi/lo rounds, CONST");
        applyStimulus(10, 1, 2, 512, 64, 0, 0, 240, 0);
        run_frames(0, 22, 1, 0, -1, 0, busy);

        $display("[TB] INCR with gap and byte wrap");
        applyStimulus(1, 1, 1, 4, 4, 3, 1, 8'hFE, 8'h10);
        run_frames(0, 2, 1, 0, -1, 0, busy);

        $display("[TB] INCR with gap under 1,0,0,1 backpressure");
        applyStimulus(1, 1, 1, 4, 4, 3, 1, 8'hFE, 8'h10);
        run_frames(1, 2, 1, 0, -1, 0, busy);

        $display("[TB] empty round");
        applyStimulus(0, 0, 1, 4, 4, 0, 0, 1, 2);
        run_frames(0, 0, 1, 0, -1, 0, busy);
        checkOutput("zero_busy_cycles", 64'(busy), 64'd2);

        $display("[TB] endless run aborted in frame 3");
        applyStimulus(1, 1, 0, 512, 512, 2, 0, 8'h33, 8'h44);
        run_frames(0, 2, 0, 2, 100, 0, busy);
        applyStimulus(1, 0, 1, 3, 3, 0, 1, 8'h80, 0);
        run_frames(2, 1, 1, 0, -1, 0, busy);

        $display("[TB] LFSR payload and reset mid-frame");
        applyStimulus(0, 1, 1, 7, 5, 1, 2, 8'h33, 8'h00);
        run_frames(2, 1, 1, 0, -1, 0, busy);
        applyStimulus(1, 0, 1, 20, 5, 0, 2, 8'h5A, 8'h00);
        run_frames(2, 0, 0, 0, 7, 1, busy);

        $display("[TB] randomized configurations");
        for (int t = 0; t < 8; t++) begin
            int nh, nl, lp, lh, ll, gp, md;
            nh = $urandom_range(0, 3);
            nl = $urandom_range(0, 3);
            lp = $urandom_range(1, 3);
            lh = $urandom_range(0, 6);
            ll = $urandom_range(0, 6);
            gp = $urandom_range(0, 3);
            md = $urandom_range(0, 3);
            applyStimulus(nh, nl, lp, lh, ll, gp, md, $urandom_range(0, 255), $urandom_range(0, 255));
            run_frames(2, lp * (nh + nl), 1, 0, -1, 0, busy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
